// File: rtl/npc_stage_ctrl.sv
// Multi-cycle instruction sequencer for the NPC core: steps the PC through
// FETCH/EXEC/MEM/COMMIT with req/ack handshakes, raises traps, counts retirements.
module npc_stage_ctrl #(
    parameter int unsigned             XLEN     = 32,
    parameter logic [XLEN-1:0]         RESET_PC = XLEN'(32'h8000_0000),
    parameter int unsigned             TIMEOUT  = 255,
    parameter int unsigned             CNT_W    = 64
) (
    input  logic             clk,
    input  logic             rst,
    output logic [XLEN-1:0]  pc,
    output logic             ifu_req,
    input  logic             ifu_ack,
    input  logic [31:0]      ifu_inst,
    output logic [31:0]      inst,
    input  logic             dec_mem_op,
    input  logic             dec_halt,
    input  logic             jump_en,
    input  logic [XLEN-1:0]  jump_pc,
    output logic             lsu_req,
    input  logic             lsu_ack,
    input  logic             lsu_err,
    output logic             commit,
    output logic             trap_en,
    output logic [3:0]       trap_cause,
    output logic [XLEN-1:0]  trap_epc,
    input  logic [XLEN-1:0]  trap_vec,
    output logic             halted,
    output logic [CNT_W-1:0] retire_cnt
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_COMMIT = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;

    localparam int unsigned WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [3:0] CAUSE_MISALIGN = 4'd0;
    localparam logic [3:0] CAUSE_FETCH    = 4'd1;
    localparam logic [3:0] CAUSE_MEM      = 4'd5;

    logic [2:0]        state;
    logic [2:0]        state_nx;
    logic [3:0]        cause_nx;
    logic [WAIT_W-1:0] wait_cnt;
    logic              timed_out;
    logic [XLEN-1:0]   npc;

    // The last waiting cycle is the one where wait_cnt reaches TIMEOUT-1;
    // an ack arriving in that same cycle still takes priority.
    assign timed_out = (wait_cnt == WAIT_W'(TIMEOUT - 1));

    always_comb begin
        state_nx = state;
        cause_nx = '0;
        case (state)
            S_IDLE:   state_nx = S_FETCH;
            S_FETCH: begin
                if (ifu_ack) begin
                    state_nx = S_EXEC;
                end else if (timed_out) begin
                    state_nx = S_TRAP;
                    cause_nx = CAUSE_FETCH;
                end
            end
            S_EXEC: begin
                if (dec_halt) begin
                    state_nx = S_HALT;
                end else if (jump_en && (jump_pc[1:0] != 2'b00)) begin
                    state_nx = S_TRAP;
                    cause_nx = CAUSE_MISALIGN;
                end else if (dec_mem_op) begin
                    state_nx = S_MEM;
                end else begin
                    state_nx = S_COMMIT;
                end
            end
            S_MEM: begin
                if (lsu_ack) begin
                    if (lsu_err) begin
                        state_nx = S_TRAP;
                        cause_nx = CAUSE_MEM;
                    end else begin
                        state_nx = S_COMMIT;
                    end
                end else if (timed_out) begin
                    state_nx = S_TRAP;
                    cause_nx = CAUSE_MEM;
                end
            end
            S_COMMIT: state_nx = S_FETCH;
            S_TRAP:   state_nx = S_FETCH;
            S_HALT:   state_nx = S_HALT;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            pc         <= RESET_PC;
            npc        <= RESET_PC;
            inst       <= '0;
            retire_cnt <= '0;
            trap_cause <= '0;
            trap_epc   <= '0;
            wait_cnt   <= '0;
        end else begin
            state <= state_nx;

            if ((state_nx == state) && ((state == S_FETCH) || (state == S_MEM)))
                wait_cnt <= wait_cnt + 1'b1;
            else
                wait_cnt <= '0;

            if ((state == S_FETCH) && ifu_ack)
                inst <= ifu_inst;

            if (state == S_EXEC)
                npc <= jump_en ? jump_pc : pc + XLEN'(4);

            // Cause/epc are captured on entry so they are valid alongside trap_en.
            if ((state_nx == S_TRAP) && (state != S_TRAP)) begin
                trap_cause <= cause_nx;
                trap_epc   <= pc;
            end

            if (state == S_COMMIT) begin
                pc         <= npc;
                retire_cnt <= retire_cnt + 1'b1;
            end else if (state == S_TRAP) begin
                pc <= trap_vec;
            end
        end
    end

    assign ifu_req = (state == S_FETCH);
    assign lsu_req = (state == S_MEM);
    assign commit  = (state == S_COMMIT);
    assign trap_en = (state == S_TRAP);
    assign halted  = (state == S_HALT);

endmodule

// File: tb/tb_npc_stage_ctrl.sv
// Directed bench for npc_stage_ctrl; a second instance with a short timeout
// covers the fetch-timeout boundary.
module tb_npc_stage_ctrl;

    logic        clk;
    logic        rst;
    logic        ifu_ack;
    logic [31:0] ifu_inst;
    logic        dec_mem_op;
    logic        dec_halt;
    logic        jump_en;
    logic [31:0] jump_pc;
    logic        lsu_ack;
    logic        lsu_err;
    logic [31:0] trap_vec;

    logic [31:0] pc, inst, trap_epc;
    logic        ifu_req, lsu_req, commit, trap_en, halted;
    logic [3:0]  trap_cause;
    logic [63:0] retire_cnt;

    logic [31:0] t_pc, t_inst, t_trap_epc;
    logic        t_ifu_req, t_lsu_req, t_commit, t_trap_en, t_halted;
    logic [3:0]  t_trap_cause;
    logic [63:0] t_retire_cnt;

    int unsigned n_checks;
    int unsigned n_fail;

    npc_stage_ctrl #(.XLEN(32), .RESET_PC(32'h8000_0000), .TIMEOUT(255), .CNT_W(64)) dut (
        .clk(clk), .rst(rst), .pc(pc), .ifu_req(ifu_req), .ifu_ack(ifu_ack),
        .ifu_inst(ifu_inst), .inst(inst), .dec_mem_op(dec_mem_op), .dec_halt(dec_halt),
        .jump_en(jump_en), .jump_pc(jump_pc), .lsu_req(lsu_req), .lsu_ack(lsu_ack),
        .lsu_err(lsu_err), .commit(commit), .trap_en(trap_en), .trap_cause(trap_cause),
        .trap_epc(trap_epc), .trap_vec(trap_vec), .halted(halted), .retire_cnt(retire_cnt)
    );

    npc_stage_ctrl #(.XLEN(32), .RESET_PC(32'h8000_0000), .TIMEOUT(4), .CNT_W(64)) dut_to (
        .clk(clk), .rst(rst), .pc(t_pc), .ifu_req(t_ifu_req), .ifu_ack(ifu_ack),
        .ifu_inst(ifu_inst), .inst(t_inst), .dec_mem_op(dec_mem_op), .dec_halt(dec_halt),
        .jump_en(jump_en), .jump_pc(jump_pc), .lsu_req(t_lsu_req), .lsu_ack(lsu_ack),
        .lsu_err(lsu_err), .commit(t_commit), .trap_en(t_trap_en), .trap_cause(t_trap_cause),
        .trap_epc(t_trap_epc), .trap_vec(trap_vec), .halted(t_halted), .retire_cnt(t_retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b1;
        ifu_ack    = 1'b1;
        ifu_inst   = 32'h0000_0013;
        dec_mem_op = 1'b0;
        dec_halt   = 1'b0;
        jump_en    = 1'b0;
        jump_pc    = '0;
        lsu_ack    = 1'b0;
        lsu_err    = 1'b0;
        trap_vec   = 32'h8000_0200;

        tick();
        tick();
        check_val("rst_pc", {32'h0, pc}, 64'h8000_0000);
        check_val("rst_retire", retire_cnt, 64'd0);
        check_val("rst_inst", {32'h0, inst}, 64'd0);
        check_val("rst_strobes", {59'd0, ifu_req, lsu_req, commit, trap_en, halted}, 64'd0);
        check_val("rst_trap", {28'h0, trap_cause, trap_epc}, 64'd0);
        rst = 1'b0;
        tick(); // IDLE -> FETCH

        // Three back-to-back nops, three cycles each
        for (int i = 0; i < 3; i++) begin
            check_val("nop_fetch_pc", {32'h0, pc}, 64'h8000_0000 + 64'(4 * i));
            check_val("nop_fetch_req", {63'd0, ifu_req}, 64'd1);
            tick();
            check_val("nop_exec_commit", {63'd0, commit}, 64'd0);
            tick();
            check_val("nop_commit", {63'd0, commit}, 64'd1);
            check_val("nop_inst", {32'h0, inst}, 64'h13);
            tick();
        end
        check_val("nop_pc_end", {32'h0, pc}, 64'h8000_000C);
        check_val("nop_retire", retire_cnt, 64'd3);

        // Load whose ack arrives on the 6th lsu_req cycle
        dec_mem_op = 1'b1;
        tick(); // EXEC
        check_val("ld_exec_req", {63'd0, lsu_req}, 64'd0);
        for (int k = 1; k <= 6; k++) begin
            tick();
            check_val("ld_lsu_req", {63'd0, lsu_req}, 64'd1);
            check_val("ld_no_commit", {63'd0, commit}, 64'd0);
            if (k == 6) lsu_ack = 1'b1;
        end
        tick();
        check_val("ld_commit", {63'd0, commit}, 64'd1);
        check_val("ld_req_drop", {63'd0, lsu_req}, 64'd0);
        lsu_ack    = 1'b0;
        dec_mem_op = 1'b0;
        tick();
        check_val("ld_pc", {32'h0, pc}, 64'h8000_0010);
        check_val("ld_retire", retire_cnt, 64'd4);

        // Aligned jump
        jump_en = 1'b1;
        jump_pc = 32'h8000_0100;
        tick();
        tick();
        check_val("jmp_commit", {63'd0, commit}, 64'd1);
        tick();
        check_val("jmp_pc", {32'h0, pc}, 64'h8000_0100);
        check_val("jmp_retire", retire_cnt, 64'd5);

        // Misaligned jump target traps
        jump_pc = 32'h8000_0102;
        tick();
        tick();
        check_val("mis_trap_en", {63'd0, trap_en}, 64'd1);
        check_val("mis_no_commit", {63'd0, commit}, 64'd0);
        jump_en = 1'b0;
        tick();
        check_val("mis_trap_done", {63'd0, trap_en}, 64'd0);
        check_val("mis_pc", {32'h0, pc}, 64'h8000_0200);
        check_val("mis_cause", {60'd0, trap_cause}, 64'd0);
        check_val("mis_epc", {32'h0, trap_epc}, 64'h8000_0100);
        check_val("mis_retire", retire_cnt, 64'd5);

        // Load with access error
        dec_mem_op = 1'b1;
        lsu_ack    = 1'b1;
        lsu_err    = 1'b1;
        tick();
        tick();
        check_val("err_lsu_req", {63'd0, lsu_req}, 64'd1);
        tick();
        check_val("err_trap_en", {63'd0, trap_en}, 64'd1);
        lsu_ack = 1'b0;
        lsu_err = 1'b0;
        tick();
        check_val("err_cause", {60'd0, trap_cause}, 64'd5);
        check_val("err_epc", {32'h0, trap_epc}, 64'h8000_0200);
        check_val("err_retire", retire_cnt, 64'd5);

        // Reset while a memory request is pending
        tick(); // EXEC
        tick(); // MEM
        check_val("rmem_req", {63'd0, lsu_req}, 64'd1);
        rst = 1'b1;
        tick();
        check_val("rmem_pc", {32'h0, pc}, 64'h8000_0000);
        check_val("rmem_req_drop", {63'd0, lsu_req}, 64'd0);
        check_val("rmem_retire", retire_cnt, 64'd0);
        check_val("rmem_commit", {63'd0, commit}, 64'd0);

        // ebreak halts until reset
        rst        = 1'b0;
        dec_mem_op = 1'b0;
        dec_halt   = 1'b1;
        tick(); // FETCH
        tick(); // EXEC
        tick(); // HALT
        for (int i = 0; i < 20; i++) begin
            if (i > 0) tick();
            check_val("halt_state", {62'd0, halted, ifu_req | lsu_req}, 64'b10);
        end

        // Fetch timeout on the TIMEOUT=4 instance
        rst      = 1'b1;
        ifu_ack  = 1'b0;
        dec_halt = 1'b0;
        tick();
        rst = 1'b0;
        tick(); // waiting cycle 1
        for (int c = 1; c <= 4; c++) begin
            if (c > 1) tick();
            check_val("to_wait", {62'd0, t_ifu_req, t_trap_en}, 64'b10);
        end
        tick();
        check_val("to_trap_en", {63'd0, t_trap_en}, 64'd1);
        tick();
        check_val("to_cause", {60'd0, t_trap_cause}, 64'd1);
        check_val("to_epc", {32'h0, t_trap_epc}, 64'h8000_0000);
        check_val("to_pc", {32'h0, t_pc}, 64'h8000_0200);
        check_val("to_idle_bus", {62'd0, t_lsu_req, t_halted}, 64'd0);

        // Ack arriving on the last waiting cycle beats the timeout
        ifu_inst = 32'h0000_0513;
        tick();
        tick();
        tick(); // waiting cycle 4
        check_val("ack4_req", {63'd0, t_ifu_req}, 64'd1);
        ifu_ack = 1'b1;
        tick();
        check_val("ack4_no_trap", {62'd0, t_trap_en, t_ifu_req}, 64'd0);
        check_val("ack4_inst", {32'h0, t_inst}, 64'h513);
        tick();
        check_val("ack4_commit", {63'd0, t_commit}, 64'd1);
        tick();
        check_val("ack4_retire", t_retire_cnt, 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
